fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  hazard-unit hold request; PC and IF/ID outputs hold.
REQ-005 redirect_valid  input  1  taken branch or jump resolved this cycle.
REQ-006 redirect_pc  input  32  branch/jump target address.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  fetch address, equal to current PC.
REQ-009 imem_ready  input  1  imem_rdata valid for the current request.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 if_valid  output  1  IF/ID register holds a live instruction.
REQ-012 if_pc  output  32  PC of the instruction in IF/ID.
REQ-013 if_instr  output  32  instruction in IF/ID.
REQ-014 flush  output  1  kill younger instructions in ID; combinational, equals redirect_valid.

Function
REQ-015 FSM states: IDLE, FETCH, HOLD, REDIRECT.
- IDLE: imem_req=0; next state FETCH.
- FETCH: imem_req=1, imem_addr=pc.
- HOLD: imem_req=0; one fetched word is held in the skid buffer.
- REDIRECT: imem_req=0 for one bubble cycle; next state FETCH.
REQ-016 In FETCH, imem_ready=1 and stall=0:
- IF/ID loads {1, pc, imem_rdata}.
- pc <= pc+4.
REQ-017 In FETCH, imem_ready=1 and stall=1:
- imem_rdata and pc go to the skid buffer.
- pc <= pc+4.
- IF/ID holds.
- next state HOLD.
REQ-018 In FETCH, imem_ready=0: stay in FETCH; if stall=0 then if_valid <= 0 (bubble), otherwise IF/ID holds.
REQ-019 In HOLD with stall=0, IF/ID loads from the skid buffer with if_valid=1, then next state FETCH; with stall=1, stay in HOLD.
REQ-020 redirect_valid has priority over stall, imem_ready and every state except reset:
- pc <= {redirect_pc[31:2], 2'b00}.
- if_valid <= 0.
- skid buffer discarded.
- next state REDIRECT.
REQ-021 Redirect latency: redirect in cycle N gives imem_addr = target with imem_req=1 in cycle N+2.
REQ-022 PC increment wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-023 imem_ready is ignored whenever imem_req=0.
REQ-024 A redirect arriving while in REDIRECT restarts the bubble with the new target.

Reset
REQ-025 On rst=1 at a clock edge:
- pc <= RESET_PC; state <= IDLE.
- if_valid <= 0, if_pc <= 0, if_instr <= 0.
- skid buffer cleared.
- imem_req = 0 in the following cycle.
REQ-026 Reset overrides redirect and stall; any fetch in flight is discarded, including reset asserted mid-operation.
REQ-027 First fetch of RESET_PC is requested two cycles after the reset edge (one IDLE cycle, then FETCH).

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN compiles in two 32-bit output ports, both wrapping and both zeroed by reset:
- fetch_cnt: increments on each IF/ID load with if_valid=1.
- flush_cnt: increments on each cycle with redirect_valid=1.
REQ-029 Without FETCH_PERF_CNT_EN, both ports and their counters are absent and all other behaviour is identical.

Structure
REQ-030 The shared package holds:
- FSM state encodings (2-bit).
- PC increment constant 4.
- The instruction-width constant 32.
REQ-031 The counters sit in one sub-module, fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN.
REQ-032 Target computation (sign-extend, shift, add) stays outside this block; fetch_ctrl only receives redirect_pc.

Verification
REQ-033 Reset then imem_ready held 1, no stall: imem_addr runs 0x0, 0x4, 0x8 starting 2 cycles after reset; if_pc follows 1 cycle later with if_valid=1.
REQ-034 stall=1 for 3 cycles while the fetch at 0x10 is accepted: IF/ID holds 0xC; after stall drops, if_pc=0x10 with the buffered word; the next request is 0x14.
REQ-035 redirect_valid=1, redirect_pc=0x0000_0103 during HOLD: flush=1 in the same cycle; buffer dropped; if_valid=0; imem_addr=0x100 two cycles later.
REQ-036 pc=0xFFFF_FFFC accepted: next imem_addr=0x0000_0000.
REQ-037 imem_ready=0 for 4 cycles in FETCH with stall=0: if_valid=0 for those cycles; imem_addr is stable.
REQ-038 rst asserted during REDIRECT with redirect_valid=1: next cycle state is IDLE, if_valid=0, pc=RESET_PC; with the macro on, fetch_cnt=0 and flush_cnt=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encodings and constants for the fetch stage.
package fetch_ctrl_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] PC_INC        = 32'd4;
    localparam logic [INSTR_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_HOLD     = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: wrapping counters of IF/ID loads and redirect cycles.
module fetch_perf_cnt
    import fetch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_fetch_inc,
    input  logic               i_flush_inc,
    output logic [INSTR_W-1:0] o_fetch_cnt,
    output logic [INSTR_W-1:0] o_flush_cnt
);

    logic [INSTR_W-1:0] r_fetch_cnt;
    logic [INSTR_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_fetch_cnt <= i_fetch_inc ? r_fetch_cnt + 1'b1 : r_fetch_cnt;
            r_flush_cnt <= i_flush_inc ? r_flush_cnt + 1'b1 : r_flush_cnt;
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing, IF/ID register and one-entry skid buffer for the fetch stage.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/flush_cnt performance counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    state_t             r_state;
    logic [31:0]        r_pc;
    logic               r_if_valid;
    logic [31:0]        r_if_pc;
    logic [INSTR_W-1:0] r_if_instr;
    logic [31:0]        r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [31:0]        w_target;
    logic [31:0]        w_pc_next;

    assign w_target  = redirect_pc & PC_ALIGN_MASK;
    assign w_pc_next = r_pc + PC_INC;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_pc      <= '0;
            r_if_instr   <= '0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
        end else if (redirect_valid) begin
            // redirect outranks stall, memory response and any held word
            r_state      <= S_REDIRECT;
            r_pc         <= w_target;
            r_if_valid   <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
        end else begin
            case (r_state)
                S_IDLE:     r_state <= S_FETCH;
                S_REDIRECT: r_state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ready) begin
                        r_pc <= w_pc_next;
                        if (stall) begin
                            r_skid_pc    <= r_pc;
                            r_skid_instr <= imem_rdata;
                            r_state      <= S_HOLD;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_pc;
                            r_if_instr <= imem_rdata;
                        end
                    end else if (!stall) begin
                        r_if_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_skid_pc;
                        r_if_instr <= r_skid_instr;
                        r_state    <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign flush     = redirect_valid;

`ifdef FETCH_PERF_CNT_EN
    logic w_if_load;

    assign w_if_load = !redirect_valid && !stall &&
                       ((r_state == S_FETCH && imem_ready) || r_state == S_HOLD);

    fetch_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .i_fetch_inc (w_if_load),
        .i_flush_inc (redirect_valid),
        .o_fetch_cnt (fetch_cnt),
        .o_flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .flush          (flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rdata = imem_req ? word_at(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: the fetch engine is either waiting out a gap, holding one word, or fetching.
    bit          m_known = 0;
    int          m_gap;
    bit          m_buf;
    logic [31:0] m_pc, m_bpc, m_bin;
    logic        m_ifv;
    logic [31:0] m_ifpc, m_ifin;
    logic [31:0] m_fc, m_flc;

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1; m_pc = 32'h0; m_gap = 1; m_buf = 0;
            m_ifv = 0; m_ifpc = 0; m_ifin = 0; m_fc = 0; m_flc = 0;
        end else if (m_known) begin
            if (redirect_valid) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC; m_gap = 1; m_buf = 0; m_ifv = 0; m_flc++;
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (m_buf) begin
                if (!stall) begin
                    m_ifv = 1; m_ifpc = m_bpc; m_ifin = m_bin; m_buf = 0; m_fc++;
                end
            end else if (imem_ready) begin
                if (stall) begin
                    m_buf = 1; m_bpc = m_pc; m_bin = word_at(m_pc);
                end else begin
                    m_ifv = 1; m_ifpc = m_pc; m_ifin = word_at(m_pc); m_fc++;
                end
                m_pc = m_pc + 32'd4;
            end else if (!stall) begin
                m_ifv = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, (m_gap == 0 && !m_buf)});
            if (m_gap == 0 && !m_buf) chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", {31'b0, if_valid}, {31'b0, m_ifv});
            chk("if_pc", if_pc, m_ifpc);
            chk("if_instr", if_instr, m_ifin);
            chk("flush", {31'b0, flush}, {31'b0, redirect_valid});
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_cnt", fetch_cnt, m_fc);
            chk("flush_cnt", flush_cnt, m_flc);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [2:0] pat [24] = '{3'b010, 3'b110, 3'b110, 3'b010, 3'b000, 3'b100, 3'b010, 3'b001,
                             3'b010, 3'b010, 3'b110, 3'b111, 3'b010, 3'b000, 3'b000, 3'b110,
                             3'b100, 3'b010, 3'b011, 3'b001, 3'b010, 3'b110, 3'b010, 3'b010};

    initial begin
        step(); step();
        rst = 1'b0;
        chk("lit_idle_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("lit_first_addr", imem_addr, 32'h0);
        chk("lit_first_req", {31'b0, imem_req}, 32'd1);
        step();
        chk("lit_addr4", imem_addr, 32'h4);
        chk("lit_ifpc0", if_pc, 32'h0);
        chk("lit_ifv1", {31'b0, if_valid}, 32'd1);
        step(); step(); step();
        chk("lit_addr10", imem_addr, 32'h10);
        chk("lit_ifpcC", if_pc, 32'hC);
        stall = 1'b1;
        step();
        chk("lit_hold_req", {31'b0, imem_req}, 32'd0);
        chk("lit_hold_ifpc", if_pc, 32'hC);
        step(); step();
        stall = 1'b0;
        step();
        chk("lit_skid_ifpc", if_pc, 32'h10);
        chk("lit_skid_instr", if_instr, 32'h0010_FFEF);
        chk("lit_after_skid", imem_addr, 32'h14);
        stall = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #1 chk("lit_flush", {31'b0, flush}, 32'd1);
        step();
        redirect_valid = 1'b0;
        chk("lit_redir_ifv", {31'b0, if_valid}, 32'd0);
        chk("lit_redir_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("lit_redir_addr", imem_addr, 32'h100);
        chk("lit_redir_req1", {31'b0, imem_req}, 32'd1);
        stall = 1'b0;
        step();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lit_bubble_ifv", {31'b0, if_valid}, 32'd0);
            chk("lit_bubble_addr", imem_addr, 32'h104);
        end
        imem_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        step(); step();
        chk("lit_top_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("lit_wrap_addr", imem_addr, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        step();
        chk("lit_rerun_addr", imem_addr, 32'h300);
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; redirect_valid = 1'b0;
        chk("lit_rst_req", {31'b0, imem_req}, 32'd0);
        chk("lit_rst_ifv", {31'b0, if_valid}, 32'd0);
        chk("lit_rst_pc", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("lit_rst_fcnt", fetch_cnt, 32'd0);
        chk("lit_rst_flcnt", flush_cnt, 32'd0);
`endif
        for (int i = 0; i < 24; i++) begin
            stall = pat[i][2]; imem_ready = pat[i][1]; redirect_valid = pat[i][0];
            redirect_pc = 32'h0000_0400 + 32'(i * 8) + 32'd1;
            step();
        end
        stall = 1'b0; imem_ready = 1'b1; redirect_valid = 1'b0;
        step(); step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
